// File: rtl/block_stream_emitter_pkg.sv
// Shared encodings, ASCII constants and keyword ROMs for the block stream emitter.
package block_stream_emitter_pkg;

  localparam logic [1:0] CMD_BEGIN = 2'b00;
  localparam logic [1:0] CMD_END   = 2'b01;
  localparam logic [1:0] CMD_WORD  = 2'b10;
  localparam logic [1:0] CMD_RSVD  = 2'b11;

  localparam logic [7:0] CH_SPACE   = 8'h20;
  localparam logic [7:0] CASE_DELTA = 8'h20;

  // Lowercase keyword spellings, index 0 is the first letter emitted.
  localparam logic [7:0] BEGIN_ROM [0:4] = '{8'h62, 8'h65, 8'h67, 8'h69, 8'h6e};
  localparam logic [7:0] END_ROM   [0:2] = '{8'h65, 8'h6e, 8'h64};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EMIT = 2'b01,
    SEP  = 2'b10
  } state_t;

  // Number of characters a command emits before its trailing space.
  function automatic logic [2:0] word_len(input logic [1:0] c);
    logic [2:0] len;
    case (c)
      CMD_BEGIN: len = 3'd5;
      CMD_END:   len = 3'd3;
      CMD_WORD:  len = 3'd1;
      default:   len = 3'd0;
    endcase
    return len;
  endfunction

  // Character at position idx of a command, with per-letter case applied to keywords.
  function automatic logic [7:0] word_char(input logic [1:0] c, input logic [7:0] ch,
                                           input logic [4:0] mask, input logic [2:0] idx);
    logic [7:0] lc;
    logic       up;
    up = 1'b0;
    case (c)
      CMD_BEGIN: begin
        if (idx < 3'd5) begin
          lc = BEGIN_ROM[idx];
          up = mask[idx];
        end else begin
          lc = CH_SPACE;
        end
      end
      CMD_END: begin
        if (idx < 3'd3) begin
          lc = END_ROM[idx[1:0]];
          up = mask[idx];
        end else begin
          lc = CH_SPACE;
        end
      end
      CMD_WORD: lc = ch;
      default:  lc = CH_SPACE;
    endcase
    return up ? (lc - CASE_DELTA) : lc;
  endfunction

endpackage

// File: rtl/block_stream_emitter_depth.sv
// Nesting-depth counter with saturation, underflow guard and sticky error flag.
module block_depth_tracker
  import block_stream_emitter_pkg::*;
#(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               accept,
  input  logic               is_begin,
  input  logic               is_end,
  output logic [DEPTH_W-1:0] depth,
  output logic               err,
  output logic               balanced
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};

  logic [DEPTH_W-1:0] depth_r;
  logic               err_r;

  // Track open BEGINs; overflow or underflow leaves depth alone and latches err.
  always_ff @(posedge clk) begin
    if (!reset) begin
      depth_r <= '0;
      err_r   <= 1'b0;
    end else if (accept && is_begin) begin
      if (depth_r == DEPTH_MAX) begin
        err_r <= 1'b1;
      end else begin
        depth_r <= depth_r + DEPTH_W'(1);
      end
    end else if (accept && is_end) begin
      if (depth_r == '0) begin
        err_r <= 1'b1;
      end else begin
        depth_r <= depth_r - DEPTH_W'(1);
      end
    end else begin
      depth_r <= depth_r;
    end
  end

  assign depth    = depth_r;
  assign err      = err_r;
  assign balanced = (depth_r == '0) && !err_r;

endmodule

// File: rtl/block_stream_emitter.sv
// Emits BEGIN/END/WORD commands as an ASCII character stream, one char per clock.
module block_stream_emitter
  import block_stream_emitter_pkg::*;
#(
  parameter int         DEPTH_W   = 8,
  parameter logic [7:0] IDLE_CHAR = 8'h20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  input  logic [7:0]         cmd_char,
  input  logic [4:0]         case_mask,
  output logic               cmd_ready,
  output logic [7:0]         out,
  output logic               out_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               err,
  output logic               balanced
);

  state_t     state_r;
  logic [2:0] idx_r;
  logic [1:0] cmd_r;
  logic [7:0] char_r;
  logic [4:0] mask_r;
  logic [7:0] out_r;
  logic       out_valid_r;

  logic       ready_s;
  logic       accept_s;
  logic       starts_word_s;
  logic [7:0] first_char_s;
  logic [7:0] next_char_s;
  logic       last_s;

  // Commands are taken whenever the current word has finished its letters.
  assign ready_s       = (state_r != EMIT);
  assign accept_s      = cmd_valid && ready_s;
  assign starts_word_s = accept_s && (cmd != CMD_RSVD);
  assign first_char_s  = word_char(cmd, cmd_char, case_mask, 3'd0);
  assign next_char_s   = word_char(cmd_r, char_r, mask_r, idx_r);
  assign last_s        = (idx_r == word_len(cmd_r));

  // Character sequencer: out always holds the character of the current state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      idx_r       <= 3'd0;
      cmd_r       <= CMD_RSVD;
      char_r      <= 8'h00;
      mask_r      <= 5'd0;
      out_r       <= IDLE_CHAR;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, SEP: begin
          if (starts_word_s) begin
            cmd_r       <= cmd;
            char_r      <= cmd_char;
            mask_r      <= case_mask;
            out_r       <= first_char_s;
            out_valid_r <= 1'b1;
            idx_r       <= 3'd1;
            state_r     <= EMIT;
          end else begin
            out_r       <= IDLE_CHAR;
            out_valid_r <= 1'b0;
            idx_r       <= 3'd0;
            state_r     <= IDLE;
          end
        end
        EMIT: begin
          out_valid_r <= 1'b1;
          if (last_s) begin
            out_r   <= CH_SPACE;
            state_r <= SEP;
          end else begin
            out_r   <= next_char_s;
            idx_r   <= idx_r + 3'd1;
            state_r <= EMIT;
          end
        end
        default: begin
          out_r       <= IDLE_CHAR;
          out_valid_r <= 1'b0;
          idx_r       <= 3'd0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  block_depth_tracker #(
    .DEPTH_W (DEPTH_W)
  ) u_depth (
    .clk      (clk),
    .reset    (reset),
    .accept   (accept_s),
    .is_begin (cmd == CMD_BEGIN),
    .is_end   (cmd == CMD_END),
    .depth    (depth),
    .err      (err),
    .balanced (balanced)
  );

  assign cmd_ready = ready_s;
  assign out       = out_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_block_stream_emitter.sv
// Self-checking bench: command table with character scoreboard plus hand-written corner sequences.
module tb_block_stream_emitter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b11;
  logic [7:0] cmd_char = 8'h00;
  logic [4:0] case_mask = 5'd0;
  logic       cmd_ready;
  logic [7:0] out;
  logic       out_valid;
  logic [7:0] depth;
  logic       err;
  logic       balanced;

  logic       cmd_valid2 = 1'b0;
  logic       cmd_ready2;
  logic [7:0] out2;
  logic       out_valid2;
  logic [1:0] depth2;
  logic       err2;
  logic       balanced2;

  int checks = 0;
  int errors = 0;
  bit sb_en = 1'b0;
  logic [7:0] sbq[$];

  always #5 clk = ~clk;

  block_stream_emitter #(.DEPTH_W(8), .IDLE_CHAR(8'h20)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_char(cmd_char),
    .case_mask(case_mask), .cmd_ready(cmd_ready), .out(out), .out_valid(out_valid),
    .depth(depth), .err(err), .balanced(balanced)
  );

  block_stream_emitter #(.DEPTH_W(2), .IDLE_CHAR(8'h20)) u_sat (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd(2'b00), .cmd_char(8'h00),
    .case_mask(5'd0), .cmd_ready(cmd_ready2), .out(out2), .out_valid(out_valid2),
    .depth(depth2), .err(err2), .balanced(balanced2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int exp_len(input logic [1:0] c);
    case (c)
      2'b00:   return 5;
      2'b01:   return 3;
      2'b10:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] exp_char(input logic [1:0] c, input logic [7:0] ch,
                                          input logic [4:0] m, input int i);
    string s;
    logic [7:0] b;
    if (c == 2'b10) return ch;
    s = (c == 2'b00) ? "begin" : "end";
    b = s[i];
    if (m[i]) b = b - 8'h20;
    return b;
  endfunction

  // Scoreboard: every valid output character must match the oldest expected one.
  always @(negedge clk) begin
    if (sb_en && reset && out_valid) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_char", {24'd0, out}, 32'h0);
      end else begin
        chk("sb_char", {24'd0, out}, {24'd0, sbq.pop_front()});
      end
    end
  end

  task automatic send(input logic [1:0] c, input logic [7:0] ch, input logic [4:0] m,
                      input logic [7:0] d, input logic e);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd = c;
    cmd_char = ch;
    case_mask = m;
    for (int i = 0; i < exp_len(c); i++) sbq.push_back(exp_char(c, ch, m, i));
    if (exp_len(c) > 0) sbq.push_back(8'h20);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("tbl_depth", {24'd0, depth}, {24'd0, d});
    chk("tbl_err", {31'd0, err}, {31'd0, e});
    chk("tbl_balanced", {31'd0, balanced}, {31'd0, (d == 8'd0) && !e});
  endtask

  typedef struct {
    logic [1:0] c;
    logic [7:0] ch;
    logic [4:0] m;
    logic [7:0] d;
    logic       e;
  } vec_t;

  vec_t tbl[8];
  string b2b;

  initial begin
    int n;
    tbl[0] = '{2'b00, 8'h00, 5'b00110, 8'd1, 1'b0};
    tbl[1] = '{2'b10, 8'h78, 5'b11111, 8'd1, 1'b0};
    tbl[2] = '{2'b01, 8'h00, 5'b00001, 8'd0, 1'b0};
    tbl[3] = '{2'b11, 8'h41, 5'b11111, 8'd0, 1'b0};
    tbl[4] = '{2'b01, 8'h00, 5'b00000, 8'd0, 1'b1};
    tbl[5] = '{2'b10, 8'h63, 5'b00000, 8'd0, 1'b1};
    tbl[6] = '{2'b00, 8'h00, 5'b11111, 8'd1, 1'b1};
    tbl[7] = '{2'b01, 8'h00, 5'b00000, 8'd0, 1'b1};

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_out", {24'd0, out}, 32'h20);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_depth", {24'd0, depth}, 32'd0);
    chk("idle_balanced", {31'd0, balanced}, 32'd1);
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);

    // Table-driven commands with character scoreboard.
    sb_en = 1'b1;
    for (int k = 0; k < 8; k++) send(tbl[k].c, tbl[k].ch, tbl[k].m, tbl[k].d, tbl[k].e);
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("sb_drained", sbq.size(), 32'd0);
    chk("sb_idle_valid", {31'd0, out_valid}, 32'd0);
    sb_en = 1'b0;

    // Reset during the third character of BEGIN aborts the word and clears err.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd = 2'b00;
    case_mask = 5'd0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_third_char", {24'd0, out}, 32'h67);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out", {24'd0, out}, 32'h20);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_depth", {24'd0, depth}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_no_resume", {31'd0, out_valid}, 32'd0);

    // BEGIN then END with cmd_valid held: one space between, no idle gap.
    b2b = "begin end ";
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd = 2'b00;
    case_mask = 5'd0;
    @(posedge clk);
    #1 cmd = 2'b01;
    for (int i = 0; i < 10; i++) begin
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
      chk("b2b_char", {24'd0, out}, {24'd0, b2b[i]});
      chk("b2b_ready", {31'd0, cmd_ready}, {31'd0, (i == 5) || (i == 9)});
      if (i == 0) chk("b2b_depth_open", {24'd0, depth}, 32'd1);
      @(posedge clk);
      #1;
      if (i == 5) cmd_valid = 1'b0;
    end
    chk("b2b_end_valid", {31'd0, out_valid}, 32'd0);
    chk("b2b_end_depth", {24'd0, depth}, 32'd0);
    chk("b2b_end_balanced", {31'd0, balanced}, 32'd1);

    // Narrow depth counter saturates at 3 on the fourth BEGIN.
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk);
      while (!cmd_ready2 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("sat_ready", {31'd0, cmd_ready2}, 32'd1);
      cmd_valid2 = 1'b1;
      @(posedge clk);
      #1 cmd_valid2 = 1'b0;
      chk("sat_depth", {30'd0, depth2}, (k < 3) ? (k + 1) : 3);
      chk("sat_err", {31'd0, err2}, {31'd0, k == 3});
    end
    chk("sat_balanced", {31'd0, balanced2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/block_stream_emitter.md
Name: block_stream_emitter

Overview:
- ASCII character-stream generator for block-structure test traffic. It is the transmitter counterpart of the begin/end block checker.
- It turns tokenised commands (BEGIN, END, single-char WORD) into one 8-bit character per clock, with a trailing space after every word.
- Per-letter upper/lower case is selectable, so checker case-insensitivity can be exercised.
- It also keeps a running nesting depth, so the expected checker verdict is available alongside the stream.

Parameters:
DEPTH_W, 8, width of nesting-depth counter
IDLE_CHAR, 8'h20, character driven on out while no word is being emitted

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-low (reset==0 clears all state on rising clk edge)
cmd_valid  input  1  command present
cmd  input  2  2'b00 BEGIN, 2'b01 END, 2'b10 WORD, 2'b11 reserved (accepted, emits nothing, no depth change)
cmd_char  input  8  character for WORD, sampled on acceptance
case_mask  input  5  bit i=1 makes letter i of the word uppercase (bit0 = first letter); sampled on acceptance
cmd_ready  output  1  emitter can accept a command this cycle
out  output  8  current character
out_valid  output  1  out carries word or separator character
depth  output  DEPTH_W  open BEGINs minus matched ENDs
err  output  1  sticky: END at depth 0, or BEGIN at max depth
balanced  output  1  depth==0 && !err

Behaviour:
- Reset (reset==0 at clk edge):
  - out=IDLE_CHAR, out_valid=0, depth=0, err=0, FSM=IDLE.
  - Hence balanced=1 and cmd_ready=1 one cycle after reset.
- Reset mid-word aborts emission immediately; no further characters of that word appear.
- Command acceptance:
  - A command is accepted when cmd_valid && cmd_ready at a rising edge (cycle N).
  - cmd, cmd_char and case_mask are latched at acceptance; depth and err update at the same edge.
- FSM states:
  - IDLE -> EMIT on accepting BEGIN/END/WORD.
  - EMIT steps a 3-bit char index: BEGIN length 5 ("b","e","g","i","n"), END length 3, WORD length 1 (cmd_char verbatim, case_mask ignored).
  - EMIT -> SEP after the last character.
  - SEP drives 8'h20 with out_valid=1.
  - SEP -> EMIT if a new command is accepted in that cycle, else SEP -> IDLE.
  - Reserved cmd: accepted, FSM stays IDLE.
- Output timing:
  - First character is registered on out with out_valid=1 in cycle N+1.
  - Consecutive characters follow every cycle with no bubbles.
- Case: letter uppercase = lowercase - 8'h20 when its case_mask bit is 1.
- cmd_ready is 1 in IDLE and in SEP, which allows back-to-back words separated by exactly one space. It is 0 in EMIT.
- In IDLE: out=IDLE_CHAR, out_valid=0.
- Depth arithmetic:
  - BEGIN increments depth.
  - END decrements depth.
  - END at depth 0: depth stays 0, err<=1.
  - BEGIN at depth all-ones: depth saturates, err<=1.
  - err clears only on reset.
- balanced is combinational from registered depth/err and reflects all accepted commands, including a word still being emitted.
- Simultaneous events: reset has priority over acceptance. Acceptance in SEP never skips the SEP character.

Decomposition:
- Shared package holds:
  - CMD_BEGIN, CMD_END, CMD_WORD, CMD_RSVD encodings
  - ASCII constants CH_SPACE=8'h20 and CASE_DELTA=8'h20
  - word ROM constants "begin"/"end" as lowercase byte arrays
  - state typedef {IDLE, EMIT, SEP}
- One natural sub-module: block_depth_tracker. It holds the depth counter, saturation/underflow and sticky err, and outputs balanced. It takes accept, is_begin, is_end.

Test Plan:
- Release reset; idle 3 cycles -> out=8'h20, out_valid=0, depth=0, balanced=1, cmd_ready=1.
- BEGIN case_mask=5'b00110 accepted at cycle N -> cycles N+1..N+6 out = "b","E","G","i","n"," ", out_valid=1; depth=1 from N+1; balanced=0.
- BEGIN then END (mask 0) presented back-to-back with cmd_valid held -> stream "begin end " with single space, no idle gap; cmd_ready low for EMIT cycles only; final depth=0, balanced=1.
- END at depth 0 -> stream "end ", depth stays 0, err=1, balanced=0. A later BEGIN+END leaves err=1 and balanced=0.
- WORD cmd_char="c" after END -> "end c " (checker sees non-keyword); depth unchanged.
- reset driven low during 3rd char of BEGIN -> next cycle out=8'h20, out_valid=0, depth=0, err=0, FSM IDLE.
- DEPTH_W=2: four BEGINs -> depth saturates at 3, err=1.
